spi_slave_rx_tx: RTL and testbench

Full-duplex SPI responder for the daisy-chain SPI subsystem, clocked by the system clock. It oversamples the initiator's `sclk`/`cs`/`mosi`, shifts received bits into `rx_data`, and drives `miso` from a host-loaded transmit buffer. It sits between the external SPI pins and the local register/host logic, at the far end of the link from the SPI initiator.

---
 rtl/spi_pkg.sv | 35 +++
 rtl/spi_sync_edge.sv | 46 ++++
 rtl/spi_slave_rx_tx.sv | 217 +++++++++++++++++++++
 tb/tb_spi_slave_rx_tx.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI responder.
// Latency: none (declarations only).
// Backpressure: not applicable.
//
// Contents: FSM state enum, latched SPI mode struct, synchronizer depth,
// and a helper that maps raw sclk rise/fall pulses onto leading/trailing
// edges for a given clock polarity.
package spi_pkg;

  localparam int SPI_SYNC_STAGES = 2;
  // Cycles after reset before the synchronized cs level is trustworthy:
  // the synchronizer stages plus the edge register all start at their
  // reset value and must be flushed with real pin data first.
  localparam int SPI_SETTLE_CYC  = SPI_SYNC_STAGES + 1;

  typedef enum logic [1:0] {
    WAIT_CS = 2'd0,
    IDLE    = 2'd1,
    SHIFT   = 2'd2,
    DONE    = 2'd3
  } spi_slv_state_e;

  typedef struct packed {
    logic cpol;
    logic cpha;
  } spi_mode_t;

  // Leading edge is the one leaving the idle level: rising for cpol=0,
  // falling for cpol=1. Call with ~cpol to get the trailing edge.
  function automatic logic spi_lead_edge(input logic pol, input logic rise,
                                         input logic fall);
    return pol ? fall : rise;
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer with registered level and rise/fall pulses.
// Latency: 3 clk from pin change to level/pulse outputs.
// Backpressure: none; pulses are single-cycle and cannot be stalled.
//
// Ports: clk, rst (async active-high), din (asynchronous pin),
//        lvl (synchronized level, aligned with the pulses),
//        rise / fall (one-cycle edge pulses).
// RST_VAL sets every stage's reset value so an idle-high pin (cs) does
// not produce a spurious edge out of reset.
module spi_sync_edge
  import spi_pkg::*;
#(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic lvl,
  output logic rise,
  output logic fall
);

  logic [SPI_SYNC_STAGES-1:0] sync_q;
  logic                       lvl_q;
  logic                       rise_q;
  logic                       fall_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= {SPI_SYNC_STAGES{RST_VAL}};
      lvl_q  <= RST_VAL;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SPI_SYNC_STAGES-2:0], din};
      lvl_q  <= sync_q[SPI_SYNC_STAGES-1];
      rise_q <= sync_q[SPI_SYNC_STAGES-1] & ~lvl_q;
      fall_q <= ~sync_q[SPI_SYNC_STAGES-1] & lvl_q;
    end
  end

  assign lvl  = lvl_q;
  assign rise = rise_q;
  assign fall = fall_q;

endmodule

// File: rtl/spi_slave_rx_tx.sv
// Full-duplex SPI responder oversampling sclk/cs/mosi on the system clock.
// Latency: pin edge to event 3 clk; miso updates 4 clk after the shift edge.
// Backpressure: tx_ready low means the tx buffer is full and tx_load is dropped.
//
// Ports: clk, rst (async active-high); SPI pins sclk, cs (active low), mosi,
//        miso; cpol/cpha (latched at frame start); host side tx_data/tx_load/
//        tx_ready, rx_data/rx_valid, frame_err.
// Build option SPI_SLV_DAISY_EN: frames may exceed DATA_W bits; miso then
// forwards received bits delayed by DATA_W and rx_data is captured at cs
// rise. Without it the frame completes on the DATA_W-th sample.
module spi_slave_rx_tx
  import spi_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sclk,
  input  logic              cs,
  input  logic              mosi,
  output logic              miso,
  input  logic              cpol,
  input  logic              cpha,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_load,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              frame_err
);

  localparam int              CNT_W      = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] CNT_FULL   = CNT_W'(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] CNT_SETTLE = CNT_W'(SPI_SETTLE_CYC);

  // ---------------------------------------------------------------------
  // Pin synchronizers
  // ---------------------------------------------------------------------
  logic sclk_lvl, sclk_rise, sclk_fall;
  logic cs_lvl, cs_rise, cs_fall;
  logic mosi_lvl, mosi_rise, mosi_fall;

  spi_sync_edge #(.RST_VAL(1'b0)) u_sync_sclk (
    .clk (clk), .rst (rst), .din (sclk),
    .lvl (sclk_lvl), .rise (sclk_rise), .fall (sclk_fall)
  );

  spi_sync_edge #(.RST_VAL(1'b1)) u_sync_cs (
    .clk (clk), .rst (rst), .din (cs),
    .lvl (cs_lvl), .rise (cs_rise), .fall (cs_fall)
  );

  spi_sync_edge #(.RST_VAL(1'b0)) u_sync_mosi (
    .clk (clk), .rst (rst), .din (mosi),
    .lvl (mosi_lvl), .rise (mosi_rise), .fall (mosi_fall)
  );

  // Only the sclk edges and the mosi level are needed by the datapath.
  logic sync_unused;
  assign sync_unused = ^{sclk_lvl, mosi_rise, mosi_fall};

  // ---------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------
  spi_slv_state_e    state_q, state_d;
  spi_mode_t         mode_q;
  logic [CNT_W-1:0]  bit_cnt_q;
  // One register serves both directions: tx bits leave from the MSB while
  // rx bits enter at the LSB, so after DATA_W bits the MSB is the first
  // received bit -- exactly the daisy-chain forwarding delay.
  logic [DATA_W-1:0] shreg_q;
  logic [DATA_W-1:0] txbuf_q;
  logic              tx_ready_q;
  logic [DATA_W-1:0] rx_data_q;
  logic              miso_q;
  logic              frame_err_q;

  logic lead, trail;
  assign lead  = spi_lead_edge(mode_q.cpol, sclk_rise, sclk_fall);
  assign trail = spi_lead_edge(~mode_q.cpol, sclk_rise, sclk_fall);

  // Word shifted out this frame: buffered word, or zeros when empty.
  logic [DATA_W-1:0] tx_word;
  assign tx_word = tx_ready_q ? '0 : txbuf_q;

  // Control strobes from the output process.
  logic ctl_start, sample_ev, shift_ev, ctl_capture, ctl_abort;
  logic [DATA_W-1:0] rx_word;

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= WAIT_CS;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      // bit_cnt doubles as the settle counter here; see SPI_SETTLE_CYC.
      WAIT_CS: if (bit_cnt_q == CNT_SETTLE && cs_lvl) state_d = IDLE;
      IDLE:    if (cs_fall) state_d = SHIFT;
      SHIFT: begin
        if (ctl_capture)    state_d = DONE;
        else if (ctl_abort) state_d = IDLE;
      end
      DONE:    state_d = IDLE;
      default: state_d = WAIT_CS;
    endcase
  end

  // ---------------------------------------------------------------------
  // FSM: outputs and datapath strobes
  // ---------------------------------------------------------------------
  always_comb begin
    ctl_start   = 1'b0;
    sample_ev   = 1'b0;
    shift_ev    = 1'b0;
    ctl_capture = 1'b0;
    ctl_abort   = 1'b0;
    rx_valid    = 1'b0;
    rx_word     = shreg_q;
    case (state_q)
      IDLE: ctl_start = cs_fall;
      SHIFT: begin
        sample_ev = mode_q.cpha ? trail : lead;
        shift_ev  = mode_q.cpha ? lead : trail;
`ifdef SPI_SLV_DAISY_EN
        // Frame length is open-ended; the last DATA_W bits are already
        // sitting in the shift register when cs rises.
        ctl_capture = cs_rise && (bit_cnt_q == CNT_FULL);
        ctl_abort   = cs_rise && (bit_cnt_q != CNT_FULL);
        rx_word     = shreg_q;
`else
        // The DATA_W-th sample completes the word; include the bit being
        // sampled this cycle.
        ctl_capture = sample_ev && (bit_cnt_q == CNT_LAST);
        ctl_abort   = cs_rise && !ctl_capture;
        rx_word     = {shreg_q[DATA_W-2:0], mosi_lvl};
`endif
      end
      DONE: rx_valid = 1'b1;
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q      <= '0;
      bit_cnt_q   <= '0;
      shreg_q     <= '0;
      txbuf_q     <= '0;
      tx_ready_q  <= 1'b1;
      rx_data_q   <= '0;
      miso_q      <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      // Shift register and bit counter
      if (ctl_start) begin
        mode_q    <= '{cpol: cpol, cpha: cpha};
        bit_cnt_q <= '0;
        shreg_q   <= tx_word;
      end else if (state_q == WAIT_CS) begin
        if (bit_cnt_q != CNT_SETTLE) bit_cnt_q <= bit_cnt_q + 1'b1;
      end else if (sample_ev) begin
        shreg_q <= {shreg_q[DATA_W-2:0], mosi_lvl};
        // Saturate so arbitrarily long daisy frames keep "at least DATA_W".
        if (bit_cnt_q != CNT_FULL) bit_cnt_q <= bit_cnt_q + 1'b1;
      end

      // miso: with cpha=0 the MSB must be on the wire before the first
      // leading edge, so it is preloaded at frame start; with cpha=1 the
      // first leading edge (a shift edge) drives it.
      if (ctl_start) begin
        miso_q <= cpha ? 1'b0 : tx_word[DATA_W-1];
      end else if (state_d != SHIFT) begin
        miso_q <= 1'b0;
      end else if (shift_ev) begin
        miso_q <= shreg_q[DATA_W-1];
      end

      // Transmit buffer: a load coinciding with frame start refills the
      // buffer for the next frame even though it was still full.
      if (ctl_start) begin
        if (tx_load) begin
          txbuf_q    <= tx_data;
          tx_ready_q <= 1'b0;
        end else begin
          tx_ready_q <= 1'b1;
        end
      end else if (tx_load && tx_ready_q) begin
        txbuf_q    <= tx_data;
        tx_ready_q <= 1'b0;
      end

      if (ctl_capture) rx_data_q <= rx_word;
      frame_err_q <= ctl_abort;
    end
  end

  assign miso      = miso_q;
  assign tx_ready  = tx_ready_q;
  assign rx_data   = rx_data_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_spi_slave_rx_tx.sv
`timescale 1ns/1ps
module tb_spi_slave_rx_tx;

  localparam int W = 8;
  localparam int H = 5;  // sclk half-period in clk cycles

  logic         clk = 1'b0;
  logic         rst, sclk, cs, mosi, miso, cpol, cpha;
  logic [W-1:0] tx_data, rx_data;
  logic         tx_load, tx_ready, rx_valid, frame_err;

  int checks = 0;
  int errors = 0;
  int rxv_cnt = 0;
  int ferr_cnt = 0;
  logic [W-1:0] rx_at_valid = '0;

  // Reference model: host-visible buffer and last good received word.
  logic [W-1:0] m_buf;
  bit           m_empty;
  logic [W-1:0] m_rx;

  // Snapshot taken right after a mid-frame reset.
  logic         snap_miso, snap_rdy;
  logic [W-1:0] snap_rx;

  always #5 clk = ~clk;

  spi_slave_rx_tx #(.DATA_W(W)) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .cs(cs), .mosi(mosi), .miso(miso),
    .cpol(cpol), .cpha(cpha), .tx_data(tx_data), .tx_load(tx_load),
    .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
    .frame_err(frame_err)
  );

  always @(negedge clk) begin
    if (rx_valid) begin
      rxv_cnt++;
      rx_at_valid = rx_data;
    end
    if (frame_err) ferr_cnt++;
  end

  function automatic void model_load(input logic [W-1:0] v);
    if (m_empty) begin
      m_buf   = v;
      m_empty = 1'b0;
    end
  endfunction

  function automatic logic [W-1:0] model_take();
    logic [W-1:0] w;
    w = m_empty ? '0 : m_buf;
    m_empty = 1'b1;
    return w;
  endfunction

  task automatic do_load(input logic [W-1:0] v);
    tx_data = v;
    tx_load = 1'b1;
    @(negedge clk);
    tx_load = 1'b0;
    model_load(v);
  endtask

  // SPI initiator. stop_at < nbits aborts early; rst_at pulses rst before
  // that bit; load_fall strobes tx_load in the cycle the DUT sees cs fall.
  task automatic spi_frame(input bit pol, input bit pha, input int nbits,
                           input logic [31:0] mo, input int stop_at,
                           input int rst_at, input bit load_fall,
                           input logic [W-1:0] load_val,
                           output logic [31:0] mi);
    mi = '0;
    cpol = pol;
    cpha = pha;
    sclk = pol;
    repeat (H) @(negedge clk);
    cs = 1'b0;
    if (!pha) mosi = mo[nbits-1];
    for (int k = 0; k < H; k++) begin
      tx_data = load_val;
      tx_load = load_fall && (k == 3);
      @(negedge clk);
    end
    tx_load = 1'b0;
    for (int i = 0; i < nbits && i != stop_at; i++) begin
      if (i == rst_at) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        snap_miso = miso;
        snap_rdy  = tx_ready;
        snap_rx   = rx_data;
      end
      if (!pha) begin
        mi = {mi[30:0], miso};
        sclk = ~pol;
        repeat (H) @(negedge clk);
        sclk = pol;
        if (i + 1 < nbits) mosi = mo[nbits-2-i];
        repeat (H) @(negedge clk);
      end else begin
        sclk = ~pol;
        mosi = mo[nbits-1-i];
        repeat (H) @(negedge clk);
        mi = {mi[30:0], miso};
        sclk = pol;
        repeat (H) @(negedge clk);
      end
    end
    cs = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; sclk = 1'b0; cs = 1'b1; mosi = 1'b0; cpol = 1'b0; cpha = 1'b0;
    tx_data = '0; tx_load = 1'b0;
    m_empty = 1'b1; m_buf = '0; m_rx = '0;
    repeat (4) @(negedge clk);
    checks++; if (miso !== 1'b0) begin errors++; $display("FAIL reset_miso: got %b want 0", miso); end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid: got %b want 0", rx_valid); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %b want 0", frame_err); end
    checks++; if (rx_data !== '0) begin errors++; $display("FAIL reset_rx_data: got %h want 00", rx_data); end
    checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL reset_tx_ready: got %b want 1", tx_ready); end
    rst = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_mode0();
    logic [31:0] mi;
    logic [W-1:0] exp_tx;
    int rv, fe;
    do_load(8'hA5);
    checks++; if (tx_ready !== 1'b0) begin errors++; $display("FAIL load_tx_ready: got %b want 0", tx_ready); end
    exp_tx = model_take();
    rv = rxv_cnt; fe = ferr_cnt;
    spi_frame(0, 0, 8, 32'h12, 99, 99, 0, '0, mi);
    m_rx = 8'h12;
    checks++; if (rx_data !== m_rx) begin errors++; $display("FAIL mode0_rx: got %h want %h", rx_data, m_rx); end
    checks++; if (rx_at_valid !== m_rx) begin errors++; $display("FAIL mode0_rx_at_valid: got %h want %h", rx_at_valid, m_rx); end
    checks++; if (rxv_cnt - rv !== 1) begin errors++; $display("FAIL mode0_rx_valid_cnt: got %0d want 1", rxv_cnt - rv); end
    checks++; if (ferr_cnt - fe !== 0) begin errors++; $display("FAIL mode0_frame_err: got %0d want 0", ferr_cnt - fe); end
    checks++; if (mi !== 32'(exp_tx)) begin errors++; $display("FAIL mode0_miso: got %h want %h", mi, exp_tx); end
    checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL mode0_tx_ready: got %b want 1", tx_ready); end
  endtask

  task automatic test_modes123();
    logic [31:0] mi;
    logic [W-1:0] exp_tx;
    for (int m = 1; m < 4; m++) begin
      do_load(8'h3C);
      exp_tx = model_take();
      spi_frame(m[1], m[0], 8, 32'hC3, 99, 99, 0, '0, mi);
      m_rx = 8'hC3;
      checks++; if (rx_data !== m_rx) begin errors++; $display("FAIL mode%0d_rx: got %h want %h", m, rx_data, m_rx); end
      checks++; if (mi !== 32'(exp_tx)) begin errors++; $display("FAIL mode%0d_miso: got %h want %h", m, mi, exp_tx); end
    end
  endtask

  task automatic test_abort();
    logic [31:0] mi;
    logic [W-1:0] exp_tx;
    int rv, fe;
    exp_tx = model_take();
    rv = rxv_cnt; fe = ferr_cnt;
    spi_frame(0, 0, 8, 32'($urandom_range(0, 255)), 5, 99, 0, '0, mi);
    checks++; if (ferr_cnt - fe !== 1) begin errors++; $display("FAIL abort_frame_err: got %0d want 1", ferr_cnt - fe); end
    checks++; if (rxv_cnt - rv !== 0) begin errors++; $display("FAIL abort_rx_valid: got %0d want 0", rxv_cnt - rv); end
    checks++; if (rx_data !== m_rx) begin errors++; $display("FAIL abort_rx_held: got %h want %h", rx_data, m_rx); end
    exp_tx = model_take();
    rv = rxv_cnt;
    spi_frame(1, 1, 8, 32'h55, 99, 99, 0, '0, mi);
    m_rx = 8'h55;
    checks++; if (rx_data !== m_rx) begin errors++; $display("FAIL after_abort_rx: got %h want %h", rx_data, m_rx); end
    checks++; if (rxv_cnt - rv !== 1) begin errors++; $display("FAIL after_abort_rx_valid: got %0d want 1", rxv_cnt - rv); end
    checks++; if (mi !== 32'(exp_tx)) begin errors++; $display("FAIL after_abort_miso: got %h want %h", mi, exp_tx); end
  endtask

  task automatic test_reset_mid_frame();
    logic [31:0] mi;
    logic [W-1:0] exp_tx;
    int rv, fe;
    do_load(8'hFF);
    exp_tx = model_take();
    rv = rxv_cnt; fe = ferr_cnt;
    spi_frame(0, 0, 8, 32'($urandom_range(0, 255)), 99, 3, 0, '0, mi);
    // Reset empties the buffer and clears the received word.
    m_empty = 1'b1; m_rx = '0;
    checks++; if (snap_miso !== 1'b0) begin errors++; $display("FAIL rst_mid_miso: got %b want 0", snap_miso); end
    checks++; if (snap_rdy !== 1'b1) begin errors++; $display("FAIL rst_mid_tx_ready: got %b want 1", snap_rdy); end
    checks++; if (snap_rx !== '0) begin errors++; $display("FAIL rst_mid_rx_data: got %h want 00", snap_rx); end
    checks++; if (mi !== 32'({exp_tx[7:5], 5'b0})) begin errors++; $display("FAIL rst_mid_miso_bits: got %h want %h", mi, {exp_tx[7:5], 5'b0}); end
    checks++; if (rxv_cnt - rv !== 0 || ferr_cnt - fe !== 0) begin errors++; $display("FAIL rst_mid_pulses: got rxv %0d ferr %0d want 0 0", rxv_cnt - rv, ferr_cnt - fe); end
    checks++; if (rx_data !== m_rx) begin errors++; $display("FAIL rst_mid_rx_after: got %h want %h", rx_data, m_rx); end
    do_load(8'($urandom_range(0, 255)));
    exp_tx = model_take();
    spi_frame(0, 1, 8, 32'h81, 99, 99, 0, '0, mi);
    m_rx = 8'h81;
    checks++; if (rx_data !== m_rx) begin errors++; $display("FAIL post_rst_rx: got %h want %h", rx_data, m_rx); end
    checks++; if (mi !== 32'(exp_tx)) begin errors++; $display("FAIL post_rst_miso: got %h want %h", mi, exp_tx); end
  endtask

  task automatic test_empty_and_same_cycle_load();
    logic [31:0] mi;
    logic [W-1:0] exp_tx, v;
    v = 8'($urandom_range(1, 255));
    exp_tx = model_take();
    model_load(v);
    spi_frame(1, 0, 8, 32'h0F, 99, 99, 1, v, mi);
    m_rx = 8'h0F;
    checks++; if (mi !== 32'(exp_tx)) begin errors++; $display("FAIL empty_miso: got %h want %h", mi, exp_tx); end
    checks++; if (tx_ready !== 1'b0) begin errors++; $display("FAIL fall_load_tx_ready: got %b want 0", tx_ready); end
    exp_tx = model_take();
    spi_frame(0, 0, 8, 32'hF0, 99, 99, 0, '0, mi);
    m_rx = 8'hF0;
    checks++; if (mi !== 32'(exp_tx)) begin errors++; $display("FAIL fall_load_miso: got %h want %h", mi, exp_tx); end
    checks++; if (rx_data !== m_rx) begin errors++; $display("FAIL fall_load_rx: got %h want %h", rx_data, m_rx); end
  endtask

  task automatic test_ignored_load();
    logic [31:0] mi;
    logic [W-1:0] exp_tx;
    do_load(8'h69);
    do_load(8'h96);
    exp_tx = model_take();
    spi_frame(1, 1, 8, 32'h3A, 99, 99, 0, '0, mi);
    m_rx = 8'h3A;
    checks++; if (mi !== 32'(exp_tx)) begin errors++; $display("FAIL ignored_load_miso: got %h want %h", mi, exp_tx); end
  endtask

  task automatic test_random();
    logic [31:0] mi;
    logic [W-1:0] exp_tx, mo;
    int rv, m;
    for (int n = 0; n < 8; n++) begin
      m  = int'($urandom_range(0, 3));
      mo = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 3) != 0) do_load(8'($urandom_range(0, 255)));
      exp_tx = model_take();
      rv = rxv_cnt;
      spi_frame(m[1], m[0], 8, 32'(mo), 99, 99, 0, '0, mi);
      m_rx = mo;
      checks++; if (rx_data !== m_rx) begin errors++; $display("FAIL rand%0d_rx: got %h want %h", n, rx_data, m_rx); end
      checks++; if (mi !== 32'(exp_tx)) begin errors++; $display("FAIL rand%0d_miso: got %h want %h", n, mi, exp_tx); end
      checks++; if (rxv_cnt - rv !== 1) begin errors++; $display("FAIL rand%0d_rx_valid: got %0d want 1", n, rxv_cnt - rv); end
    end
  endtask

  task automatic test_long_frame();
    logic [31:0] mi, exp_mi;
    logic [W-1:0] exp_tx;
    int rv, fe;
    do_load(8'hF0);
    exp_tx = model_take();
    rv = rxv_cnt; fe = ferr_cnt;
`ifdef SPI_SLV_DAISY_EN
    // One DATA_W stage of a chain: own word, then the first received word.
    spi_frame(0, 0, 16, 32'h1234, 99, 99, 0, '0, mi);
    exp_mi = {16'h0, exp_tx, 8'h12};
    m_rx = 8'h34;
`else
    // Bits past DATA_W are ignored and read back as zero.
    spi_frame(0, 0, 10, 32'h2D3, 99, 99, 0, '0, mi);
    exp_mi = {22'h0, exp_tx, 2'b00};
    m_rx = 8'hB4;
`endif
    checks++; if (mi !== exp_mi) begin errors++; $display("FAIL long_miso: got %h want %h", mi, exp_mi); end
    checks++; if (rx_data !== m_rx) begin errors++; $display("FAIL long_rx: got %h want %h", rx_data, m_rx); end
    checks++; if (rxv_cnt - rv !== 1) begin errors++; $display("FAIL long_rx_valid: got %0d want 1", rxv_cnt - rv); end
    checks++; if (ferr_cnt - fe !== 0) begin errors++; $display("FAIL long_frame_err: got %0d want 0", ferr_cnt - fe); end
  endtask

  initial begin
    test_reset();
    test_mode0();
    test_modes123();
    test_abort();
    test_reset_mid_frame();
    test_empty_and_same_cycle_load();
    test_ignored_load();
    test_random();
    test_long_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
